// File: rtl/sh2_wb_pkg.sv
// Shared register-index types and helpers for the SH-2 writeback scheduler.
// Index space is R0..R15 plus PR at 16; anything above is illegal.
package sh2_wb_pkg;

    localparam int NUM_REGS = 17;
    localparam logic [4:0] REG_PR = 5'd16;

    typedef logic [4:0] reg_idx_t;

    // Retire stage: a popped load destination kept busy through the
    // register file's delayed port-B commit.
    typedef struct packed {
        logic     v;
        reg_idx_t dst;
    } ret_t;

    function automatic logic is_valid_reg(input reg_idx_t r);
        return r <= REG_PR;
    endfunction

endpackage

// File: rtl/sh2_ldq.sv
// In-order load destination queue with per-entry valid bits and three
// parallel destination-match outputs for hazard detection.
module sh2_ldq
    import sh2_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     CLK,
    input  logic     RST_N,
    input  logic     push,
    input  logic     pop,
    input  reg_idx_t push_dst,
    input  reg_idx_t ra_addr,
    input  reg_idx_t rb_addr,
    input  reg_idx_t ex_addr,
    output reg_idx_t head,
    output logic     full,
    output logic     empty,
    output logic [2:0] cnt,
    output logic     ra_hit,
    output logic     rb_hit,
    output logic     ex_hit
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    reg_idx_t          dst_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [2:0]        cnt_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // A simultaneous push/pop on a full queue hits the same slot; the later
    // set of vld_q wins, which is the intended result.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            vld_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= 3'd0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= ptr_inc(rd_ptr);
            end
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: the destination array carries no reset; valid bits alone decide
    // whether an entry means anything, so stale contents are harmless.
    always_ff @(posedge CLK) begin
        if (push) begin
            dst_q[wr_ptr] <= push_dst;
        end
    end

    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ra_hit = 1'b0;
        rb_hit = 1'b0;
        ex_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && dst_q[i] == ra_addr) ra_hit = 1'b1;
            if (vld_q[i] && dst_q[i] == rb_addr) rb_hit = 1'b1;
            if (vld_q[i] && dst_q[i] == ex_addr) ex_hit = 1'b1;
        end
    end

    assign head  = dst_q[rd_ptr];
    assign cnt   = cnt_q;
    assign full  = (cnt_q == 3'(DEPTH));
    assign empty = (cnt_q == 3'd0);

endmodule

// File: rtl/sh2_wb_sched.sv
// Writeback scheduler: execute results on port A, returning load data on
// port B, plus the load scoreboard that raises STALL on load hazards.
module sh2_wb_sched
    import sh2_wb_pkg::*;
#(
    parameter int LDQ_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic        EN,
    input  logic        EX_WE,
    input  logic [4:0]  EX_DST,
    input  logic [31:0] EX_D,
    input  logic        LD_ISSUE,
    input  logic [4:0]  LD_DST,
    input  logic        LD_DONE,
    input  logic [31:0] LD_DATA,
    input  logic [4:0]  RA_ADDR,
    input  logic [4:0]  RB_ADDR,
    input  logic        RA_USE,
    input  logic        RB_USE,
    output logic [4:0]  WA_ADDR,
    output logic [4:0]  WB_ADDR,
    output logic [31:0] WA_D,
    output logic [31:0] WB_D,
    output logic        WAE,
    output logic        WBE,
    output logic        STALL,
    output logic [2:0]  LDQ_CNT,
    output logic        ERR
);

    logic     adv;
    logic     push;
    logic     pop;
    reg_idx_t head;
    logic     full;
    logic     empty;
    logic     ra_hit;
    logic     rb_hit;
    logic     ex_hit;
    ret_t     ret_q;
    logic     ra_busy;
    logic     rb_busy;
    logic     ex_busy;
    logic     stall_raw;
    logic     err_set;
    logic     err_q;

    assign adv = CE & EN & RST_N;

    // A full queue only takes a new load when the head retires on the same edge.
    assign pop  = LD_DONE & adv & ~empty;
    assign push = LD_ISSUE & adv & is_valid_reg(LD_DST) & (~full | LD_DONE);

    sh2_ldq #(
        .DEPTH (LDQ_DEPTH)
    ) u_ldq (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (push),
        .pop      (pop),
        .push_dst (LD_DST),
        .ra_addr  (RA_ADDR),
        .rb_addr  (RB_ADDR),
        .ex_addr  (EX_DST),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .cnt      (LDQ_CNT),
        .ra_hit   (ra_hit),
        .rb_hit   (rb_hit),
        .ex_hit   (ex_hit)
    );

    assign ra_busy = ra_hit | (ret_q.v & (ret_q.dst == RA_ADDR));
    assign rb_busy = rb_hit | (ret_q.v & (ret_q.dst == RB_ADDR));
    assign ex_busy = ex_hit | (ret_q.v & (ret_q.dst == EX_DST));

    assign stall_raw = (RA_USE & ra_busy)
                     | (RB_USE & rb_busy)
                     | (EX_WE & ex_busy)
                     | (LD_ISSUE & full & ~LD_DONE);

    assign STALL = RST_N & stall_raw;

    assign WA_ADDR = EX_DST;
    assign WA_D    = EX_D;
    assign WAE     = EX_WE & adv & ~stall_raw & is_valid_reg(EX_DST);

    assign WB_ADDR = head;
    assign WB_D    = LD_DATA;
    assign WBE     = pop;

    // Port B commits a cycle late, so the popped destination stays busy one more CE cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ret_q <= '0;
        end else if (adv) begin
            ret_q.v   <= pop;
            ret_q.dst <= head;
        end
    end

    assign err_set = adv & ((LD_DONE & empty)
                          | (LD_ISSUE & ~is_valid_reg(LD_DST))
                          | (EX_WE & ~is_valid_reg(EX_DST)));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;

endmodule

// File: tb/tb_sh2_wb_sched.sv
// Directed bench for sh2_wb_sched: queue-based reference model checked on
// every falling edge, plus hand-computed literal expectations.
module tb_sh2_wb_sched;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST_N, CE, EN;
    logic        EX_WE, LD_ISSUE, LD_DONE, RA_USE, RB_USE;
    logic [4:0]  EX_DST, LD_DST, RA_ADDR, RB_ADDR;
    logic [31:0] EX_D, LD_DATA;
    logic [4:0]  WA_ADDR, WB_ADDR;
    logic [31:0] WA_D, WB_D;
    logic        WAE, WBE, STALL, ERR;
    logic [2:0]  LDQ_CNT;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    sh2_wb_sched #(.LDQ_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .EN(EN),
        .EX_WE(EX_WE), .EX_DST(EX_DST), .EX_D(EX_D),
        .LD_ISSUE(LD_ISSUE), .LD_DST(LD_DST), .LD_DONE(LD_DONE), .LD_DATA(LD_DATA),
        .RA_ADDR(RA_ADDR), .RB_ADDR(RB_ADDR), .RA_USE(RA_USE), .RB_USE(RB_USE),
        .WA_ADDR(WA_ADDR), .WB_ADDR(WB_ADDR), .WA_D(WA_D), .WB_D(WB_D),
        .WAE(WAE), .WBE(WBE), .STALL(STALL), .LDQ_CNT(LDQ_CNT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending destinations in issue order, retiring slot, sticky error.
    logic [4:0] mq[$];
    bit         m_ret_v = 0;
    logic [4:0] m_ret_dst = '0;
    bit         m_err = 0;

    function automatic bit m_busy(input logic [4:0] x);
        foreach (mq[i]) if (mq[i] == x) return 1'b1;
        return m_ret_v && (m_ret_dst == x);
    endfunction

    always @(posedge CLK) begin
        if (!RST_N) begin
            mq.delete();
            m_ret_v = 0;
            m_err   = 0;
        end else if (CE && EN) begin
            m_ret_v = 0;
            if (LD_DONE) begin
                if (mq.size() == 0) m_err = 1;
                else begin
                    m_ret_dst = mq.pop_front();
                    m_ret_v   = 1;
                end
            end
            if (LD_ISSUE) begin
                if (LD_DST > 5'd16) m_err = 1;
                else if (mq.size() < DEPTH) mq.push_back(LD_DST);
            end
            if (EX_WE && EX_DST > 5'd16) m_err = 1;
        end
    end

    bit e_adv, e_stall, e_wae, e_wbe;
    always @(negedge CLK) begin
        if (cmp_en) begin
            e_adv   = CE && EN && RST_N;
            e_stall = RST_N && ((RA_USE && m_busy(RA_ADDR)) || (RB_USE && m_busy(RB_ADDR)) ||
                                (EX_WE && m_busy(EX_DST)) ||
                                (LD_ISSUE && mq.size() == DEPTH && !LD_DONE));
            e_wae   = EX_WE && e_adv && !e_stall && (EX_DST <= 5'd16);
            e_wbe   = LD_DONE && e_adv && (mq.size() != 0);
            check("model STALL", 32'(STALL), 32'(e_stall));
            check("model WAE", 32'(WAE), 32'(e_wae));
            check("model WBE", 32'(WBE), 32'(e_wbe));
            check("model LDQ_CNT", 32'(LDQ_CNT), 32'(mq.size()));
            check("model ERR", 32'(ERR), 32'(m_err));
            if (e_wae) begin
                check("model WA_ADDR", 32'(WA_ADDR), 32'(EX_DST));
                check("model WA_D", WA_D, EX_D);
            end
            if (e_wbe) begin
                check("model WB_ADDR", 32'(WB_ADDR), 32'(mq[0]));
                check("model WB_D", WB_D, LD_DATA);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        EX_WE = 0; LD_ISSUE = 0; LD_DONE = 0; RA_USE = 0; RB_USE = 0;
        EX_DST = '0; LD_DST = '0; RA_ADDR = '0; RB_ADDR = '0;
        EX_D = '0; LD_DATA = '0;
    endtask

    task automatic do_reset();
        RST_N = 0;
        tick();
        RST_N = 1;
    endtask

    initial begin
        idle();
        CE = 1; EN = 1; RST_N = 0;
        tick();
        cmp_en = 1;
        tick();
        RST_N = 1;
        #1;
        check("reset LDQ_CNT", 32'(LDQ_CNT), 32'd0);
        check("reset ERR", 32'(ERR), 32'd0);
        check("reset STALL", 32'(STALL), 32'd0);

        // Plain execute write on port A.
        EX_WE = 1; EX_DST = 5'd3; EX_D = 32'h1234_5678;
        #1;
        check("ex WAE", 32'(WAE), 32'd1);
        check("ex WA_ADDR", 32'(WA_ADDR), 32'd3);
        check("ex WA_D", WA_D, 32'h1234_5678);
        check("ex STALL", 32'(STALL), 32'd0);
        tick();
        idle();

        // Read-after-load on R5.
        LD_ISSUE = 1; LD_DST = 5'd5;
        tick();
        LD_ISSUE = 0; RA_USE = 1; RA_ADDR = 5'd5;
        #1;
        check("ral STALL pending", 32'(STALL), 32'd1);
        check("ral LDQ_CNT", 32'(LDQ_CNT), 32'd1);
        tick();
        LD_DONE = 1; LD_DATA = 32'hDEAD_BEEF;
        #1;
        check("ral WBE", 32'(WBE), 32'd1);
        check("ral WB_ADDR", 32'(WB_ADDR), 32'd5);
        check("ral WB_D", WB_D, 32'hDEAD_BEEF);
        check("ral STALL at done", 32'(STALL), 32'd1);
        tick();
        LD_DONE = 0;
        #1;
        check("ral STALL retire", 32'(STALL), 32'd1);
        check("ral LDQ_CNT drained", 32'(LDQ_CNT), 32'd0);
        tick();
        check("ral STALL released", 32'(STALL), 32'd0);
        idle();

        // Fill the queue, then issue while full.
        LD_ISSUE = 1; LD_DST = 5'd1;
        tick();
        LD_DST = 5'd2;
        tick();
        LD_DST = 5'd4;
        #1;
        check("full STALL", 32'(STALL), 32'd1);
        check("full LDQ_CNT", 32'(LDQ_CNT), 32'd2);
        tick();
        check("full held LDQ_CNT", 32'(LDQ_CNT), 32'd2);
        LD_DONE = 1; LD_DATA = 32'h0000_0011;
        #1;
        check("full+done STALL", 32'(STALL), 32'd0);
        check("full+done WB_ADDR", 32'(WB_ADDR), 32'd1);
        tick();
        LD_ISSUE = 0; LD_DATA = 32'h0000_0022;
        #1;
        check("full+done LDQ_CNT", 32'(LDQ_CNT), 32'd2);
        check("drain WB_ADDR 2", 32'(WB_ADDR), 32'd2);
        tick();
        LD_DATA = 32'h0000_0044;
        #1;
        check("drain WB_ADDR 4", 32'(WB_ADDR), 32'd4);
        tick();
        idle();
        tick();

        // Write-after-load on PR.
        LD_ISSUE = 1; LD_DST = 5'd16;
        tick();
        LD_ISSUE = 0; EX_WE = 1; EX_DST = 5'd16; EX_D = 32'hA5A5_0001;
        #1;
        check("pr WAE blocked", 32'(WAE), 32'd0);
        check("pr STALL", 32'(STALL), 32'd1);
        tick();
        LD_DONE = 1; LD_DATA = 32'h0000_0160;
        tick();
        LD_DONE = 0;
        #1;
        check("pr STALL retire", 32'(STALL), 32'd1);
        tick();
        check("pr WAE", 32'(WAE), 32'd1);
        check("pr WA_ADDR", 32'(WA_ADDR), 32'd16);
        tick();
        idle();

        // Two loads to the same destination.
        LD_ISSUE = 1; LD_DST = 5'd6;
        tick();
        tick();
        LD_ISSUE = 0; RB_USE = 1; RB_ADDR = 5'd6; LD_DONE = 1; LD_DATA = 32'h0000_0606;
        tick();
        check("dup STALL one left", 32'(STALL), 32'd1);
        tick();
        LD_DONE = 0;
        #1;
        check("dup STALL retire", 32'(STALL), 32'd1);
        tick();
        check("dup STALL clear", 32'(STALL), 32'd0);
        idle();

        // Protocol errors: done on empty queue, illegal destinations.
        LD_DONE = 1; LD_DATA = 32'hFFFF_0000;
        #1;
        check("empty WBE", 32'(WBE), 32'd0);
        tick();
        LD_DONE = 0;
        #1;
        check("empty ERR", 32'(ERR), 32'd1);
        EX_WE = 1; EX_DST = 5'd17; EX_D = 32'h0000_0017;
        #1;
        check("ex17 WAE", 32'(WAE), 32'd0);
        tick();
        idle();
        tick();
        check("ERR sticky", 32'(ERR), 32'd1);
        RST_N = 0;
        #1;
        check("rst STALL gated", 32'(STALL), 32'd0);
        tick();
        RST_N = 1;
        #1;
        check("rst ERR clear", 32'(ERR), 32'd0);
        LD_ISSUE = 1; LD_DST = 5'd20;
        tick();
        LD_ISSUE = 0;
        #1;
        check("ld20 LDQ_CNT", 32'(LDQ_CNT), 32'd0);
        check("ld20 ERR", 32'(ERR), 32'd1);
        do_reset();

        // Reset discards pending loads.
        LD_ISSUE = 1; LD_DST = 5'd7;
        tick();
        LD_DST = 5'd8;
        tick();
        LD_ISSUE = 0; RA_USE = 1; RA_ADDR = 5'd7;
        RST_N = 0;
        #1;
        check("midrst STALL", 32'(STALL), 32'd0);
        check("midrst WAE", 32'(WAE), 32'd0);
        tick();
        RST_N = 1;
        #1;
        check("midrst LDQ_CNT", 32'(LDQ_CNT), 32'd0);
        check("midrst STALL after", 32'(STALL), 32'd0);
        RA_USE = 0; LD_DONE = 1;
        #1;
        check("midrst WBE", 32'(WBE), 32'd0);
        tick();
        LD_DONE = 0;
        #1;
        check("midrst ERR", 32'(ERR), 32'd1);
        do_reset();

        // Clock enable gating.
        LD_ISSUE = 1; LD_DST = 5'd9;
        tick();
        LD_ISSUE = 0; CE = 0; LD_DONE = 1; LD_DATA = 32'h0909_0909;
        #1;
        check("ce0 WBE", 32'(WBE), 32'd0);
        tick();
        check("ce0 LDQ_CNT", 32'(LDQ_CNT), 32'd1);
        CE = 1; EN = 0; LD_DONE = 0; EX_WE = 1; EX_DST = 5'd2; EX_D = 32'h0000_0002;
        #1;
        check("en0 WAE", 32'(WAE), 32'd0);
        tick();
        EN = 1; EX_WE = 0; LD_DONE = 1;
        #1;
        check("ce1 WB_ADDR", 32'(WB_ADDR), 32'd9);
        tick();
        idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
